// File: rtl/coloring_search_seq_if.sv
// Host/checker-facing signal bundle for the colouring candidate generator.
// The master side is the host controller plus checker; the slave side is the generator.
interface coloring_search_seq_if #(
    parameter int NUM_VERT   = 6,
    parameter int COLOR_BITS = 2
);
    localparam int CAND_W = NUM_VERT * COLOR_BITS;
    localparam int CNT_W  = CAND_W + 1;

    logic              start_i;
    logic              resume_i;
    logic              mode_i;
    logic              abort_i;
    logic              ok_i;
    logic [CAND_W-1:0] cand_o;
    logic              cand_valid_o;
    logic              busy_o;
    logic              done_o;
    logic              found_o;
    logic [CAND_W-1:0] sol_o;
    logic [CNT_W-1:0]  count_o;

    modport master (
        output start_i, resume_i, mode_i, abort_i, ok_i,
        input  cand_o, cand_valid_o, busy_o, done_o, found_o, sol_o, count_o
    );

    modport slave (
        input  start_i, resume_i, mode_i, abort_i, ok_i,
        output cand_o, cand_valid_o, busy_o, done_o, found_o, sol_o, count_o
    );
endinterface

// File: rtl/coloring_search_seq.sv
// Sequential candidate generator feeding the combinational 6-vertex colouring checker.
// Walks every colour assignment in ascending order: find-first (with resume) or count-all.
module coloring_search_seq #(
    parameter int NUM_VERT   = 6,
    parameter int COLOR_BITS = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    coloring_search_seq_if.slave bus
);
    localparam int CAND_W = NUM_VERT * COLOR_BITS;
    localparam int CNT_W  = CAND_W + 1;
    localparam logic [CAND_W-1:0] CAND_LAST = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CAND_W-1:0] cand_q;
    logic [CAND_W-1:0] sol_q;
    logic [CNT_W-1:0]  count_q;
    logic              found_q;
    logic              mode_q;

    logic last_cand;
    logic sol_at_end;
    logic resume_go;
    logic resume_fail;
    logic hit;

    // Candidate increment saturates at all-ones so the search never wraps.
    function automatic logic [CAND_W-1:0] cand_sat_inc(input logic [CAND_W-1:0] v);
        return (v == CAND_LAST) ? v : v + CAND_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] count_sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    assign last_cand   = (cand_q == CAND_LAST);
    assign sol_at_end  = (sol_q == CAND_LAST);
    // A resume only makes sense after a find-first hit with room left to continue.
    assign resume_go   = found_q && !mode_q && !sol_at_end;
    assign resume_fail = !found_q || sol_at_end;
    assign hit         = (state_q == SEARCH) && bus.ok_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    state_d = SEARCH;
                end else if (bus.resume_i) begin
                    if (resume_go) begin
                        state_d = SEARCH;
                    end else if (resume_fail) begin
                        state_d = FINISH;
                    end
                end
            end
            SEARCH: begin
                if (bus.abort_i) begin
                    state_d = IDLE;
                end else if (last_cand || (!mode_q && bus.ok_i)) begin
                    state_d = FINISH;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy_o       = 1'b0;
        bus.cand_valid_o = 1'b0;
        bus.done_o       = 1'b0;
        unique case (state_q)
            SEARCH: begin
                bus.busy_o       = 1'b1;
                bus.cand_valid_o = 1'b1;
            end
            FINISH:  bus.done_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_q  <= '0;
            sol_q   <= '0;
            count_q <= '0;
            found_q <= 1'b0;
            mode_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start_i) begin
                        cand_q  <= '0;
                        count_q <= '0;
                        found_q <= 1'b0;
                        mode_q  <= bus.mode_i;
                    end else if (bus.resume_i) begin
                        if (resume_go) begin
                            cand_q <= cand_sat_inc(sol_q);
                        end else if (resume_fail) begin
                            found_q <= 1'b0;
                        end
                    end
                end
                SEARCH: begin
                    // Abort wins over a verdict arriving in the same cycle.
                    if (bus.abort_i) begin
                        cand_q <= '0;
                    end else if (!mode_q) begin
                        if (hit) begin
                            sol_q   <= cand_q;
                            found_q <= 1'b1;
                        end else if (last_cand) begin
                            found_q <= 1'b0;
                        end else begin
                            cand_q <= cand_sat_inc(cand_q);
                        end
                    end else begin
                        if (hit) begin
                            count_q <= count_sat_inc(count_q);
                            if (!found_q) begin
                                sol_q   <= cand_q;
                                found_q <= 1'b1;
                            end
                        end
                        if (!last_cand) begin
                            cand_q <= cand_sat_inc(cand_q);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.cand_o  = cand_q;
    assign bus.sol_o   = sol_q;
    assign bus.found_o = found_q;
    assign bus.count_o = count_q;

endmodule
